output_unit_fsm: RTL and testbench

- Per-output-port controller of the mesh router; the switch-side counterpart of the input unit FSMs.
- Collects switch requests from the NUM_IN input units that routed a packet to this port.
- Grants one input by round-robin and locks the port to it until that packet's tail flit has passed.
- Forwards flits through a registered output stage, gated by credit-based flow control against the downstream input buffer.

---
 rtl/output_unit_fsm.sv | 184 ++++++++++++++++++
 tb/tb_output_unit_fsm.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_unit_fsm.sv
// output_unit_fsm: per-output-port controller of a mesh router.
// Round-robin arbitration between input units, packet-level port lock,
// a registered output stage and credit-based flow control.
module output_unit_fsm #(
  parameter int NUM_IN    = 5,
  parameter int FLIT_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_IN-1:0]              i_req,
  output logic [NUM_IN-1:0]              o_grant,
  input  logic [NUM_IN*FLIT_W-1:0]       i_flit,
  input  logic [NUM_IN-1:0]              i_flit_valid,
  output logic [NUM_IN-1:0]              o_ready,
  output logic [FLIT_W-1:0]              o_flit,
  output logic                           o_flit_valid,
  input  logic                           i_credit,
  output logic [1:0]                     o_state,
  output logic [$clog2(NUM_IN)-1:0]      o_owner,
  output logic [$clog2(BUF_DEPTH+1)-1:0] o_credits,
  output logic                           o_credit_err,
  output logic                           o_proto_err
);

  localparam int OWNER_W = $clog2(NUM_IN);
  localparam int CRED_W  = $clog2(BUF_DEPTH + 1);
  localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(BUF_DEPTH);
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_IN - 1);
  localparam logic [OWNER_W:0]   NUM_IN_W = (OWNER_W + 1)'(NUM_IN);
  localparam logic [1:0]         T_BODY   = 2'b01;
  localparam logic [1:0]         T_TAIL   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACTIVE  = 2'b01,
    S_WAITING = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic                flit_valid_q, flit_valid_d;
  logic                credit_err_q, credit_err_d;
  logic                proto_err_q, proto_err_d;
  logic                first_q, first_d;   // next accepted flit opens the packet

  // Unpack the flattened flit bus so the owner can be selected by index.
  logic [FLIT_W-1:0] flit_arr [NUM_IN];
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign flit_arr[gi] = i_flit[gi*FLIT_W +: FLIT_W];
  end

  // Candidate gi is the input gi positions after the round-robin pointer.
  logic [OWNER_W:0]   cand_sum [NUM_IN];
  logic [OWNER_W-1:0] cand_idx [NUM_IN];
  logic [NUM_IN-1:0]  cand_req;
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, rr_ptr_q} + (OWNER_W + 1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= NUM_IN_W) ? OWNER_W'(cand_sum[gi] - NUM_IN_W)
                                                     : cand_sum[gi][OWNER_W-1:0];
    assign cand_req[gi] = i_req[cand_idx[gi]];
  end

  logic               grant_found;
  logic [OWNER_W-1:0] grant_idx;

  // Pick the requester closest to the pointer; scanning downwards lets the lowest offset win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  // Switch ack is combinational and only issued while the port is free.
  always_comb begin
    o_grant = '0;
    if (state_q == S_IDLE && grant_found) o_grant[grant_idx] = 1'b1;
  end

  logic              ready_any;
  logic              accept;
  logic [FLIT_W-1:0] owner_flit;
  logic [1:0]        owner_type;

  assign ready_any  = (state_q == S_ACTIVE) && (credits_q != '0);
  assign owner_flit = flit_arr[owner_q];
  assign owner_type = owner_flit[FLIT_W-2 -: 2];
  assign accept     = ready_any && i_flit_valid[owner_q];

  // Only the owning input may push flits, and only with a downstream slot free.
  always_comb begin
    o_ready = '0;
    if (ready_any) o_ready[owner_q] = 1'b1;
  end

  // Credit counter: consume on accept, return on i_credit, saturate and flag overflow.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (accept && !i_credit) begin
      credits_d = credits_q - 1'b1;
    end else if (!accept && i_credit) begin
      if (credits_q == CRED_MAX) credit_err_d = 1'b1;
      else                       credits_d    = credits_q + 1'b1;
    end
  end

  // Output stage, protocol check and port state, all judged on the post-update credit count.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    first_d      = first_q;
    proto_err_d  = proto_err_q;
    flit_d       = flit_q;
    flit_valid_d = accept;
    if (accept) begin
      flit_d  = owner_flit;
      first_d = 1'b0;
      if (first_q && (owner_type == T_BODY || owner_type == T_TAIL)) proto_err_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          first_d  = 1'b1;
          state_d  = (credits_d == '0) ? S_WAITING : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // TAIL and HEAD_TAIL both carry the high type bit.
        if (accept && owner_type[1])  state_d = S_IDLE;
        else if (credits_d == '0)     state_d = S_WAITING;
      end
      S_WAITING: begin
        if (credits_d != '0) state_d = S_ACTIVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credits_q    <= CRED_MAX;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      credit_err_q <= 1'b0;
      proto_err_q  <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credits_q    <= credits_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      credit_err_q <= credit_err_d;
      proto_err_q  <= proto_err_d;
      first_q      <= first_d;
    end
  end

  assign o_state      = state_q;
  assign o_owner      = owner_q;
  assign o_credits    = credits_q;
  assign o_flit       = flit_q;
  assign o_flit_valid = flit_valid_q;
  assign o_credit_err = credit_err_q;
  assign o_proto_err  = proto_err_q;

endmodule

// File: tb/tb_output_unit_fsm.sv
// tb_output_unit_fsm: directed scenarios plus a randomized run against a packet-level reference model.
module tb_output_unit_fsm;

  localparam int NUM_IN    = 5;
  localparam int FLIT_W    = 32;
  localparam int BUF_DEPTH = 4;
  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NUM_IN-1:0]      i_req;
  logic [NUM_IN-1:0]      o_grant;
  logic [NUM_IN*FLIT_W-1:0] i_flit;
  logic [NUM_IN-1:0]      i_flit_valid;
  logic [NUM_IN-1:0]      o_ready;
  logic [FLIT_W-1:0]      o_flit;
  logic                   o_flit_valid;
  logic                   i_credit;
  logic [1:0]             o_state;
  logic [2:0]             o_owner;
  logic [2:0]             o_credits;
  logic                   o_credit_err;
  logic                   o_proto_err;

  logic [FLIT_W-1:0] flits [NUM_IN];
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_pack
    assign i_flit[gi*FLIT_W +: FLIT_W] = flits[gi];
  end

  output_unit_fsm #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_req(i_req), .o_grant(o_grant), .i_flit(i_flit),
    .i_flit_valid(i_flit_valid), .o_ready(o_ready), .o_flit(o_flit), .o_flit_valid(o_flit_valid),
    .i_credit(i_credit), .o_state(o_state), .o_owner(o_owner), .o_credits(o_credits),
    .o_credit_err(o_credit_err), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: port mode 0 free, 1 forwarding, 2 starved of credits.
  int   m_mode, m_owner, m_ptr, m_cred;
  bit   m_cerr, m_perr, m_first, m_ovalid;
  logic [FLIT_W-1:0] m_oflit;
  logic [NUM_IN-1:0] e_grant, e_ready;
  bit   e_acc;
  int   e_gk;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int pl);
    return {1'b1, t, 29'(pl)};
  endfunction

  function automatic logic [NUM_IN-1:0] onehot(input int k);
    return NUM_IN'(1 << k);
  endfunction

  function automatic bit bitk(input logic [NUM_IN-1:0] v, input int k);
    return ((v >> k) & NUM_IN'(1)) != '0;
  endfunction

  task automatic model_comb();
    e_grant = '0;
    e_ready = '0;
    e_gk    = -1;
    if (m_mode == 0)
      for (int off = 0; off < NUM_IN; off++)
        if (e_gk < 0 && bitk(i_req, (m_ptr + off) % NUM_IN)) e_gk = (m_ptr + off) % NUM_IN;
    if (e_gk >= 0) e_grant = onehot(e_gk);
    if (m_mode == 1 && m_cred > 0) e_ready = onehot(m_owner);
    e_acc = (m_mode == 1) && (m_cred > 0) && bitk(i_flit_valid, m_owner);
  endtask

  task automatic model_step();
    logic [FLIT_W-1:0] f;
    int nc;
    if (!reset_n) begin
      m_mode = 0; m_owner = 0; m_ptr = 0; m_cred = BUF_DEPTH;
      m_cerr = 0; m_perr = 0; m_first = 0; m_oflit = '0; m_ovalid = 0;
      return;
    end
    f  = flits[3'(m_owner)];
    nc = m_cred - (e_acc ? 1 : 0) + (i_credit ? 1 : 0);
    if (nc > BUF_DEPTH) begin nc = BUF_DEPTH; m_cerr = 1; end
    m_ovalid = e_acc;
    if (e_acc) begin
      m_oflit = f;
      if (m_first && (f[30:29] == BODY || f[30:29] == TAIL)) m_perr = 1;
      m_first = 0;
    end
    case (m_mode)
      0: if (e_gk >= 0) begin
           m_owner = e_gk; m_ptr = (e_gk + 1) % NUM_IN; m_first = 1;
           m_mode = (nc == 0) ? 2 : 1;
         end
      1: if (e_acc && (f[30:29] == TAIL || f[30:29] == HT)) m_mode = 0;
         else if (nc == 0) m_mode = 2;
      default: if (nc > 0) m_mode = 1;
    endcase
    m_cred = nc;
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_quiet();
    i_req = '0; i_flit_valid = '0; i_credit = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; drive_quiet(); tick(); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NUM_IN; k++) flits[3'(k)] = '1;
    reset_n = 1'b0; drive_quiet(); tick(); tick(); settle();
    total++; if (o_state !== 2'd0)      begin bad++; $display("FAIL reset_state got=%0h exp=0", o_state); end
    total++; if (o_grant !== 5'd0)      begin bad++; $display("FAIL reset_grant got=%0h exp=0", o_grant); end
    total++; if (o_ready !== 5'd0)      begin bad++; $display("FAIL reset_ready got=%0h exp=0", o_ready); end
    total++; if (o_flit !== 32'd0)      begin bad++; $display("FAIL reset_flit got=%0h exp=0", o_flit); end
    total++; if (o_flit_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", o_flit_valid); end
    total++; if (o_credits !== 3'd4)    begin bad++; $display("FAIL reset_credits got=%0d exp=4", o_credits); end
    total++; if (o_owner !== 3'd0)      begin bad++; $display("FAIL reset_owner got=%0d exp=0", o_owner); end
    total++; if (o_credit_err !== 1'b0 || o_proto_err !== 1'b0)
      begin bad++; $display("FAIL reset_errs got=%0b%0b exp=00", o_credit_err, o_proto_err); end
    reset_n = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_single_packet();
    i_req = 5'b00001; settle();
    total++; if (o_grant !== 5'b00001) begin bad++; $display("FAIL sp_grant got=%b exp=00001", o_grant); end
    tick(); i_req = '0;
    flits[0] = mk(HEAD, 'h11); i_flit_valid = 5'b00001; settle();
    total++; if (o_state !== 2'd1)      begin bad++; $display("FAIL sp_active got=%0d exp=1", o_state); end
    total++; if (o_ready !== 5'b00001)  begin bad++; $display("FAIL sp_ready got=%b exp=00001", o_ready); end
    total++; if (o_flit_valid !== 1'b0) begin bad++; $display("FAIL sp_latency got=%0b exp=0", o_flit_valid); end
    tick(); flits[0] = mk(BODY, 'h12); settle();
    total++; if (o_flit_valid !== 1'b1 || o_flit !== mk(HEAD, 'h11))
      begin bad++; $display("FAIL sp_head got=%0b/%h exp=1/%h", o_flit_valid, o_flit, mk(HEAD, 'h11)); end
    total++; if (o_credits !== 3'd3) begin bad++; $display("FAIL sp_cred3 got=%0d exp=3", o_credits); end
    tick(); flits[0] = mk(TAIL, 'h13); settle();
    total++; if (o_flit_valid !== 1'b1 || o_flit !== mk(BODY, 'h12))
      begin bad++; $display("FAIL sp_body got=%0b/%h exp=1/%h", o_flit_valid, o_flit, mk(BODY, 'h12)); end
    tick(); i_flit_valid = '0; settle();
    total++; if (o_flit_valid !== 1'b1 || o_flit !== mk(TAIL, 'h13))
      begin bad++; $display("FAIL sp_tail got=%0b/%h exp=1/%h", o_flit_valid, o_flit, mk(TAIL, 'h13)); end
    total++; if (o_credits !== 3'd1) begin bad++; $display("FAIL sp_cred1 got=%0d exp=1", o_credits); end
    total++; if (o_state !== 2'd0)   begin bad++; $display("FAIL sp_idle got=%0d exp=0", o_state); end
    tick(); settle();
    total++; if (o_flit_valid !== 1'b0 || o_flit !== mk(TAIL, 'h13))
      begin bad++; $display("FAIL sp_hold got=%0b/%h exp=0/%h", o_flit_valid, o_flit, mk(TAIL, 'h13)); end
    i_credit = 1'b1; tick(); tick(); tick(); i_credit = 1'b0; settle();
    total++; if (o_credits !== 3'd4) begin bad++; $display("FAIL sp_refill got=%0d exp=4", o_credits); end
    $display("single packet done");
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 4, 0};
    do_reset();
    i_req = 5'b10011;
    for (int n = 0; n < 4; n++) begin
      settle();
      total++; if (o_grant !== onehot(order[n]))
        begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", n, o_grant, onehot(order[n])); end
      tick();
      flits[3'(order[n])] = mk(HT, 'h100 + n); i_flit_valid = onehot(order[n]); i_credit = 1'b1; settle();
      total++; if (o_owner !== 3'(order[n])) begin bad++; $display("FAIL rr_owner%0d got=%0d exp=%0d", n, o_owner, order[n]); end
      total++; if (o_ready !== onehot(order[n])) begin bad++; $display("FAIL rr_ready%0d got=%b exp=%b", n, o_ready, onehot(order[n])); end
      tick(); i_flit_valid = '0; i_credit = 1'b0; settle();
      total++; if (o_flit !== mk(HT, 'h100 + n) || o_flit_valid !== 1'b1)
        begin bad++; $display("FAIL rr_flit%0d got=%h exp=%h", n, o_flit, mk(HT, 'h100 + n)); end
      total++; if (o_credits !== 3'd4 || o_state !== 2'd0)
        begin bad++; $display("FAIL rr_after%0d got=cred %0d state %0d exp=cred 4 state 0", n, o_credits, o_state); end
      $display("rr packet from input %0d", order[n]);
    end
    i_req = '0; tick();
  endtask

  function automatic logic [FLIT_W-1:0] stall_flit(input int p);
    return mk((p == 0) ? HEAD : (p == 5) ? TAIL : BODY, 'h200 + p);
  endfunction

  task automatic test_credit_stall();
    do_reset();
    i_req = 5'b00100; tick(); i_req = '0;
    i_flit_valid = 5'b00100;
    for (int p = 0; p < 4; p++) begin flits[2] = stall_flit(p); tick(); end
    settle();
    total++; if (o_state !== 2'd2)  begin bad++; $display("FAIL st_wait got=%0d exp=2", o_state); end
    total++; if (o_ready !== 5'd0)  begin bad++; $display("FAIL st_ready got=%b exp=00000", o_ready); end
    total++; if (o_credits !== 3'd0 || o_flit !== stall_flit(3))
      begin bad++; $display("FAIL st_fourth got=cred %0d flit %h exp=cred 0 flit %h", o_credits, o_flit, stall_flit(3)); end
    flits[2] = stall_flit(4); tick(); settle();
    total++; if (o_flit_valid !== 1'b0) begin bad++; $display("FAIL st_gap got=%0b exp=0", o_flit_valid); end
    i_credit = 1'b1; tick(); i_credit = 1'b0; settle();
    total++; if (o_state !== 2'd1 || o_ready !== 5'b00100)
      begin bad++; $display("FAIL st_resume got=state %0d ready %b exp=state 1 ready 00100", o_state, o_ready); end
    tick(); flits[2] = stall_flit(5); settle();
    total++; if (o_state !== 2'd2 || o_flit !== stall_flit(4) || o_flit_valid !== 1'b1)
      begin bad++; $display("FAIL st_fifth got=state %0d flit %h exp=state 2 flit %h", o_state, o_flit, stall_flit(4)); end
    i_credit = 1'b1; tick(); i_credit = 1'b0; tick(); i_flit_valid = '0; settle();
    total++; if (o_state !== 2'd0 || o_flit !== stall_flit(5) || o_credits !== 3'd0)
      begin bad++; $display("FAIL st_tail got=state %0d flit %h cred %0d exp=state 0 flit %h cred 0", o_state, o_flit, o_credits, stall_flit(5)); end
    i_credit = 1'b1; for (int n = 0; n < 4; n++) tick(); i_credit = 1'b0;
    $display("credit stall packet done");
  endtask

  task automatic test_credit_corner();
    do_reset();
    i_req = 5'b01000; tick(); i_req = '0;
    i_flit_valid = 5'b01000;
    flits[3] = mk(HEAD, 'h300); tick();
    flits[3] = mk(BODY, 'h301); tick();
    flits[3] = mk(BODY, 'h302); tick();
    flits[3] = mk(BODY, 'h303); i_credit = 1'b1; settle();
    total++; if (o_credits !== 3'd1) begin bad++; $display("FAIL cc_pre got=%0d exp=1", o_credits); end
    tick(); i_credit = 1'b0; flits[3] = mk(TAIL, 'h304); settle();
    total++; if (o_credits !== 3'd1 || o_state !== 2'd1)
      begin bad++; $display("FAIL cc_simul got=cred %0d state %0d exp=cred 1 state 1", o_credits, o_state); end
    tick(); i_flit_valid = '0; settle();
    total++; if (o_credits !== 3'd0 || o_state !== 2'd0)
      begin bad++; $display("FAIL cc_tail got=cred %0d state %0d exp=cred 0 state 0", o_credits, o_state); end
    i_credit = 1'b1; for (int n = 0; n < 5; n++) tick(); i_credit = 1'b0; settle();
    total++; if (o_credits !== 3'd4 || o_credit_err !== 1'b1)
      begin bad++; $display("FAIL cc_overflow got=cred %0d err %0b exp=cred 4 err 1", o_credits, o_credit_err); end
    total++; if (o_proto_err !== 1'b0) begin bad++; $display("FAIL cc_proto got=%0b exp=0", o_proto_err); end
    $display("credit corner done");
  endtask

  task automatic test_proto_err();
    do_reset();
    i_req = 5'b00010; tick(); i_req = '0;
    flits[1] = mk(BODY, 'h400); i_flit_valid = 5'b00010; tick();
    flits[1] = mk(TAIL, 'h401); settle();
    total++; if (o_proto_err !== 1'b1) begin bad++; $display("FAIL pe_flag got=%0b exp=1", o_proto_err); end
    total++; if (o_flit !== mk(BODY, 'h400) || o_flit_valid !== 1'b1)
      begin bad++; $display("FAIL pe_fwd got=%h exp=%h", o_flit, mk(BODY, 'h400)); end
    tick(); i_flit_valid = '0; settle();
    total++; if (o_state !== 2'd0 || o_proto_err !== 1'b1)
      begin bad++; $display("FAIL pe_release got=state %0d err %0b exp=state 0 err 1", o_state, o_proto_err); end
    i_req = 5'b00001; tick(); i_req = '0;
    flits[0] = mk(TAIL, 'h402); i_flit_valid = 5'b00001; tick(); i_flit_valid = '0; settle();
    total++; if (o_state !== 2'd0 || o_flit !== mk(TAIL, 'h402))
      begin bad++; $display("FAIL pe_tailfirst got=state %0d flit %h exp=state 0 flit %h", o_state, o_flit, mk(TAIL, 'h402)); end
    $display("protocol error packets done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_req = 5'b00010; tick(); i_req = '0;
    flits[1] = mk(HEAD, 'h500); i_flit_valid = 5'b00010; tick();
    flits[1] = mk(BODY, 'h501); reset_n = 1'b0; tick();
    reset_n = 1'b1; i_flit_valid = '0; settle();
    total++; if (o_state !== 2'd0 || o_flit_valid !== 1'b0)
      begin bad++; $display("FAIL mr_state got=state %0d valid %0b exp=state 0 valid 0", o_state, o_flit_valid); end
    total++; if (o_credits !== 3'd4 || o_owner !== 3'd0)
      begin bad++; $display("FAIL mr_cred got=cred %0d owner %0d exp=cred 4 owner 0", o_credits, o_owner); end
    i_req = 5'b00110; settle();
    total++; if (o_grant !== 5'b00010) begin bad++; $display("FAIL mr_ptr got=%b exp=00010", o_grant); end
    i_req = '0; tick();
    $display("mid-packet reset done");
  endtask

  task automatic test_random();
    bit sending [NUM_IN];
    bit want    [NUM_IN];
    bit badf    [NUM_IN];
    int pos     [NUM_IN];
    int len     [NUM_IN];
    int seq = 0;
    logic [1:0] t;
    do_reset();
    for (int k = 0; k < NUM_IN; k++) begin sending[k] = 0; want[k] = 0; pos[k] = 0; len[k] = 1; badf[k] = 0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      i_req = '0; i_flit_valid = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        if (sending[k]) begin
          if (pos[k] == 0) t = (len[k] == 1) ? (badf[k] ? TAIL : HT) : (badf[k] ? BODY : HEAD);
          else             t = (pos[k] == len[k] - 1) ? TAIL : BODY;
          flits[3'(k)] = mk(t, k * 65536 + seq * 8 + pos[k]);
          if ($urandom_range(0, 3) != 0) i_flit_valid = i_flit_valid | onehot(k);
        end else begin
          if (!want[k]) want[k] = ($urandom_range(0, 3) == 0);
          flits[3'(k)] = $urandom();
          if ($urandom_range(0, 1) != 0) i_flit_valid = i_flit_valid | onehot(k);
          if (want[k]) i_req = i_req | onehot(k);
        end
      end
      i_credit = ((BUF_DEPTH - m_cred) > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
      model_comb(); settle();
      total++; if (o_grant !== e_grant) begin bad++; $display("FAIL rnd_grant c%0d got=%b exp=%b", cyc, o_grant, e_grant); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, o_ready, e_ready); end
      total++; if (o_state !== 2'(m_mode)) begin bad++; $display("FAIL rnd_state c%0d got=%0d exp=%0d", cyc, o_state, m_mode); end
      total++; if (o_owner !== 3'(m_owner)) begin bad++; $display("FAIL rnd_owner c%0d got=%0d exp=%0d", cyc, o_owner, m_owner); end
      total++; if (o_credits !== 3'(m_cred)) begin bad++; $display("FAIL rnd_credits c%0d got=%0d exp=%0d", cyc, o_credits, m_cred); end
      total++; if (o_flit_valid !== m_ovalid) begin bad++; $display("FAIL rnd_valid c%0d got=%0b exp=%0b", cyc, o_flit_valid, m_ovalid); end
      total++; if (o_flit !== m_oflit) begin bad++; $display("FAIL rnd_flit c%0d got=%h exp=%h", cyc, o_flit, m_oflit); end
      total++; if (o_credit_err !== m_cerr) begin bad++; $display("FAIL rnd_cerr c%0d got=%0b exp=%0b", cyc, o_credit_err, m_cerr); end
      total++; if (o_proto_err !== m_perr) begin bad++; $display("FAIL rnd_perr c%0d got=%0b exp=%0b", cyc, o_proto_err, m_perr); end
      if (e_gk >= 0) begin
        sending[e_gk] = 1; want[e_gk] = 0; pos[e_gk] = 0;
        len[e_gk] = $urandom_range(1, 6); badf[e_gk] = ($urandom_range(0, 9) == 0);
      end
      if (e_acc) begin
        pos[m_owner]++;
        if (pos[m_owner] == len[m_owner]) begin
          sending[m_owner] = 0;
          $display("rnd packet input=%0d len=%0d seq=%0d cycle=%0d", m_owner, len[m_owner], seq, cyc);
          seq++;
        end
      end
      tick();
    end
    drive_quiet(); tick();
  endtask

  initial begin
    reset_n = 1'b0;
    drive_quiet();
    for (int k = 0; k < NUM_IN; k++) flits[3'(k)] = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_credit_stall();
    test_credit_corner();
    test_proto_err();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
